// File: rtl/rv_muldiv_unit.sv
// rtl/rv_muldiv_unit.sv - iterative RV32M/RV64M multiply/divide execute unit
//
// Ports:
//   CLK, RST        clock and synchronous active-high reset
//   start, op       issue request with RISC-V funct3 op (MUL..REMU)
//   rs1, rs2        operand A (multiplicand/dividend), operand B (multiplier/divisor)
//   flush           abort any in-flight op; result register is left untouched
//   ready, busy     may accept start / op in progress
//   done, result    one-cycle completion pulse and registered result
module rv_muldiv_unit #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic             flush,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  // Multiply: hi/lo form the running product, lo starts as |B|, opd holds |A|.
  // Divide:   hi is the partial remainder, lo shifts dividend out / quotient in, opd holds |B|.
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opd_q, opd_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             neg_q, neg_d;   // operand signs differ: negate product/quotient
  logic             sa_q, sa_d;     // dividend negative: negate remainder
  logic [CW-1:0]    cnt_q, cnt_d;

  // Issue-time decode
  logic             a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
  logic [WIDTH-1:0] abs_a, abs_b, fast_res;

  always_comb begin
    a_signed = !((op == 3'b011) || (op[2] && op[0]));
    b_signed = a_signed && (op != 3'b010);
    a_neg    = a_signed && rs1[WIDTH-1];
    b_neg    = b_signed && rs2[WIDTH-1];
    abs_a    = a_neg ? -rs1 : rs1;
    abs_b    = b_neg ? -rs2 : rs2;
    div_zero = op[2] && (rs2 == '0);
    div_ovf  = op[2] && !op[0] && (rs1 == MOST_NEG) && (rs2 == '1);
    if (div_zero) fast_res = op[1] ? rs1 : '1;
    else          fast_res = op[1] ? '0 : rs1;
  end

  // One CALC cycle: BITS_PER_CYCLE shift-add or restoring-divide steps
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH:0]   rem_t, sum_t;

  always_comb begin
    step_hi = hi_q;
    step_lo = lo_q;
    rem_t   = '0;
    sum_t   = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (op_q[2]) begin
        rem_t   = {step_hi, step_lo[WIDTH-1]};
        step_lo = {step_lo[WIDTH-2:0], 1'b0};
        if (rem_t >= {1'b0, opd_q}) begin
          rem_t      = rem_t - {1'b0, opd_q};
          step_lo[0] = 1'b1;
        end
        step_hi = rem_t[WIDTH-1:0];
      end else begin
        sum_t   = {1'b0, step_hi} + (step_lo[0] ? {1'b0, opd_q} : '0);
        step_lo = {sum_t[0], step_lo[WIDTH-1:1]};
        step_hi = sum_t[WIDTH:1];
      end
    end
  end

  // Sign correction and selection, used on the final CALC cycle
  logic [2*WIDTH-1:0] prod_abs, prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s, calc_res;

  always_comb begin
    prod_abs = {step_hi, step_lo};
    prod_s   = neg_q ? -prod_abs : prod_abs;
    quo_s    = neg_q ? -step_lo : step_lo;
    rem_s    = sa_q ? -step_hi : step_hi;
    calc_res = rem_s;
    case (op_q)
      3'b000:                 calc_res = prod_s[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: calc_res = prod_s[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         calc_res = quo_s;
      default:                calc_res = rem_s;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opd_d    = opd_q;
    result_d = result_q;
    neg_d    = neg_q;
    sa_d     = sa_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE, S_FIN: begin
        if (start) begin
          op_d = op;
          if (div_zero || div_ovf) begin
            state_d  = S_FIN;
            result_d = fast_res;
          end else begin
            state_d = S_CALC;
            cnt_d   = CW'(N - 1);
            neg_d   = a_neg ^ b_neg;
            sa_d    = a_neg;
            hi_d    = '0;
            lo_d    = op[2] ? abs_a : abs_b;
            opd_d   = op[2] ? abs_b : abs_a;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        hi_d = step_hi;
        lo_d = step_lo;
        if (cnt_q == '0) begin
          state_d  = S_FIN;
          result_d = calc_res;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Abort beats any issue in the same cycle; the last result stays visible.
    if (flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opd_q    <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      sa_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opd_q    <= opd_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      sa_q     <= sa_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ready  = (state_q != S_CALC);
  assign busy   = (state_q == S_CALC);
  assign done   = (state_q == S_FIN);
  assign result = result_q;

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// tb/tb_rv_muldiv_unit.sv - directed self-checking bench for rv_muldiv_unit
module tb_rv_muldiv_unit;

  localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010, OP_MULHU = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;

  logic        CLK = 1'b0;
  logic        RST, start, flush;
  logic [2:0]  op;
  logic [31:0] rs1, rs2;
  logic        ready1, busy1, done1, ready4, busy4, done4;
  logic [31:0] result1, result4;
  int          checks = 0;
  int          errors = 0;

  always #5 CLK = ~CLK;

  rv_muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_bpc1 (
    .CLK(CLK), .RST(RST), .start(start), .op(op), .rs1(rs1), .rs2(rs2), .flush(flush),
    .ready(ready1), .busy(busy1), .done(done1), .result(result1));

  rv_muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_bpc4 (
    .CLK(CLK), .RST(RST), .start(start), .op(op), .rs1(rs1), .rs2(rs2), .flush(flush),
    .ready(ready4), .busy(busy4), .done(done4), .result(result4));

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Issues one op and waits (bounded) for done on the selected instance.
  // lat = cycles after the issuing edge until done is seen; -1 on timeout.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit sel4, output int lat, output logic [31:0] res, output bit bsy);
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    bsy = 1'b0;
    while (((sel4 ? done4 : done1) !== 1'b1) && (lat < 200)) begin
      if ((sel4 ? busy4 : busy1) === 1'b1) bsy = 1'b1;
      tick();
      lat++;
    end
    if ((sel4 ? busy4 : busy1) === 1'b1) bsy = 1'b1;
    res = sel4 ? result4 : result1;
    if (lat >= 200) lat = -1;
  endtask

  task automatic test_reset();
    RST = 1'b1; start = 1'b0; flush = 1'b0; op = '0; rs1 = '0; rs2 = '0;
    tick();
    tick();
    RST = 1'b0;
    checks++;
    if ({ready1, busy1, done1} !== 3'b100) begin errors++; $display("FAIL reset_ctl1 got=%b expected=100", {ready1, busy1, done1}); end
    checks++;
    if (result1 !== 32'h0) begin errors++; $display("FAIL reset_result1 got=%h expected=00000000", result1); end
    checks++;
    if ({ready4, busy4, done4} !== 3'b100) begin errors++; $display("FAIL reset_ctl4 got=%b expected=100", {ready4, busy4, done4}); end
    checks++;
    if (result4 !== 32'h0) begin errors++; $display("FAIL reset_result4 got=%h expected=00000000", result4); end
  endtask

  task automatic test_mul();
    logic [2:0]  t_op [4];
    logic [31:0] t_a [4], t_b [4], t_e [4];
    int lat, bad;
    logic [31:0] res;
    bit bsy;
    op = OP_MUL; rs1 = 32'd7; rs2 = 32'hFFFFFFFD; start = 1'b1;
    tick();
    start = 1'b0;
    bad = 0;
    for (int c = 1; c <= 32; c++) begin
      if (busy1 !== 1'b1 || done1 !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL mul_busy_window bad_cycles=%0d expected 0", bad); end
    checks++;
    if ({done1, busy1} !== 2'b10) begin errors++; $display("FAIL mul_done_k33 got done,busy=%b expected 10", {done1, busy1}); end
    checks++;
    if (result1 !== 32'hFFFFFFEB) begin errors++; $display("FAIL mul_result got=%h expected=ffffffeb", result1); end
    tick();
    checks++;
    if (done1 !== 1'b0) begin errors++; $display("FAIL mul_done_pulse got=%b expected 0", done1); end

    t_op = '{OP_MULH, OP_MULHU, OP_MULHSU, OP_MUL};
    t_a  = '{32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'h12345678};
    t_b  = '{32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'h00000010};
    t_e  = '{32'h40000000, 32'h40000000, 32'hFFFFFFFF, 32'h23456780};
    for (int i = 0; i < 4; i++) begin
      issue(t_op[i], t_a[i], t_b[i], 1'b0, lat, res, bsy);
      checks++;
      if (lat != 33) begin errors++; $display("FAIL mul_lat[%0d] got=%0d expected 33", i, lat); end
      checks++;
      if (res !== t_e[i]) begin errors++; $display("FAIL mul_res[%0d] got=%h expected=%h", i, res, t_e[i]); end
    end
  endtask

  task automatic test_div();
    logic [2:0]  t_op [7];
    logic [31:0] t_a [7], t_b [7], t_e [7];
    int lat;
    logic [31:0] res;
    bit bsy;
    t_op = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_DIVU};
    t_a  = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd7, 32'd7, 32'h80000000};
    t_b  = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF};
    t_e  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFD, 32'd1, 32'd0};
    for (int i = 0; i < 7; i++) begin
      issue(t_op[i], t_a[i], t_b[i], 1'b0, lat, res, bsy);
      checks++;
      if (lat != 33 || bsy !== 1'b1) begin errors++; $display("FAIL div_lat[%0d] got lat=%0d busy=%b expected 33/1", i, lat, bsy); end
      checks++;
      if (res !== t_e[i]) begin errors++; $display("FAIL div_res[%0d] got=%h expected=%h", i, res, t_e[i]); end
    end
  endtask

  task automatic test_fast_path();
    logic [2:0]  t_op [6];
    logic [31:0] t_a [6], t_b [6], t_e [6];
    int lat;
    logic [31:0] res;
    bit bsy;
    t_op = '{OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_DIV, OP_REM};
    t_a  = '{32'h55, 32'h55, 32'd5, 32'h1234, 32'h80000000, 32'h80000000};
    t_b  = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    t_e  = '{32'hFFFFFFFF, 32'h55, 32'hFFFFFFFF, 32'h1234, 32'h80000000, 32'd0};
    for (int i = 0; i < 6; i++) begin
      issue(t_op[i], t_a[i], t_b[i], 1'b0, lat, res, bsy);
      checks++;
      if (lat != 1 || bsy !== 1'b0) begin errors++; $display("FAIL fast_lat[%0d] got lat=%0d busy=%b expected 1/0", i, lat, bsy); end
      checks++;
      if (res !== t_e[i]) begin errors++; $display("FAIL fast_res[%0d] got=%h expected=%h", i, res, t_e[i]); end
    end
  endtask

  task automatic test_flush();
    int lat, dones;
    logic [31:0] res;
    bit bsy;
    issue(OP_DIVU, 32'd100, 32'd7, 1'b0, lat, res, bsy);
    checks++;
    if (res !== 32'd14) begin errors++; $display("FAIL flush_setup got=%h expected=0000000e", res); end
    op = OP_MUL; rs1 = 32'd7; rs2 = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1; start = 1'b1; op = OP_DIVU; rs1 = 32'd0; rs2 = 32'd0;
    tick();
    flush = 1'b0; start = 1'b0;
    checks++;
    if ({ready1, busy1, done1} !== 3'b100) begin errors++; $display("FAIL flush_calc_idle got=%b expected=100", {ready1, busy1, done1}); end
    checks++;
    if (result1 !== 32'd14) begin errors++; $display("FAIL flush_calc_hold got=%h expected=0000000e", result1); end
    flush = 1'b1; start = 1'b1;
    tick();
    flush = 1'b0; start = 1'b0;
    checks++;
    if (done1 !== 1'b0 || result1 !== 32'd14) begin errors++; $display("FAIL flush_start_drop got done=%b result=%h expected 0/0000000e", done1, result1); end
    dones = 0;
    repeat (40) begin
      if (done1 === 1'b1) dones++;
      tick();
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL flush_no_done got=%0d expected 0", dones); end
    issue(OP_DIVU, 32'd9, 32'd3, 1'b0, lat, res, bsy);
    checks++;
    if (lat != 33 || res !== 32'd3) begin errors++; $display("FAIL flush_resume got lat=%0d res=%h expected 33/00000003", lat, res); end
    issue(OP_DIVU, 32'h77, 32'd0, 1'b0, lat, res, bsy);
    flush = 1'b1;
    #1;
    checks++;
    if (done1 !== 1'b1) begin errors++; $display("FAIL flush_fin_done got=%b expected 1", done1); end
    tick();
    flush = 1'b0;
    checks++;
    if (done1 !== 1'b0 || result1 !== 32'hFFFFFFFF) begin errors++; $display("FAIL flush_fin_after got done=%b result=%h expected 0/ffffffff", done1, result1); end
  endtask

  task automatic test_ignored_start();
    int lat;
    op = OP_DIVU; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    op = OP_MUL; rs1 = 32'd2; rs2 = 32'd2; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 4;
    while (done1 !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
    checks++;
    if (lat != 33 || result1 !== 32'd14) begin errors++; $display("FAIL ignored_start got lat=%0d res=%h expected 33/0000000e", lat, result1); end
    tick();
    checks++;
    if (done1 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL ignored_no_queue got done=%b busy=%b expected 0/0", done1, busy1); end
  endtask

  task automatic test_bpc4();
    logic [2:0]  t_op [5];
    logic [31:0] t_a [5], t_b [5], t_e [5];
    int lat, lat2, want;
    logic [31:0] res;
    bit bsy;
    issue(OP_DIVU, 32'hFFFFFFFF, 32'd3, 1'b1, lat, res, bsy);
    checks++;
    if (lat != 9 || res !== 32'h55555555) begin errors++; $display("FAIL bpc4_divu got lat=%0d res=%h expected 9/55555555", lat, res); end
    checks++;
    if (ready4 !== 1'b1) begin errors++; $display("FAIL bpc4_fin_ready got=%b expected 1", ready4); end
    issue(OP_REMU, 32'd1000, 32'd7, 1'b1, lat2, res, bsy);
    checks++;
    if (lat + lat2 != 18 || res !== 32'd6) begin errors++; $display("FAIL bpc4_back_to_back got lat=%0d res=%h expected 18/00000006", lat + lat2, res); end
    t_op = '{OP_MULH, OP_MUL, OP_REM, OP_DIV, OP_DIV};
    t_a  = '{32'h80000000, 32'h12345678, 32'hFFFFFFF9, 32'd7, 32'h80000000};
    t_b  = '{32'h80000000, 32'h00000010, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF};
    t_e  = '{32'h40000000, 32'h23456780, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000};
    for (int i = 0; i < 5; i++) begin
      issue(t_op[i], t_a[i], t_b[i], 1'b1, lat, res, bsy);
      want = (i == 4) ? 1 : 9;
      checks++;
      if (lat != want || res !== t_e[i]) begin errors++; $display("FAIL bpc4_vec[%0d] got lat=%0d res=%h expected %0d/%h", i, lat, res, want, t_e[i]); end
    end
  endtask

  task automatic test_rst_mid_calc();
    int dones;
    op = OP_DIVU; rs1 = 32'hFFFFFFFF; rs2 = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    checks++;
    if (busy4 !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got=%b expected 1", busy4); end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++;
    if ({busy4, done4} !== 2'b00 || result4 !== 32'h0 || ready4 !== 1'b1) begin
      errors++; $display("FAIL rst_mid4 got busy,done=%b result=%h ready=%b expected 00/00000000/1", {busy4, done4}, result4, ready4);
    end
    checks++;
    if ({busy1, done1} !== 2'b00 || result1 !== 32'h0) begin errors++; $display("FAIL rst_mid1 got busy,done=%b result=%h expected 00/00000000", {busy1, done1}, result1); end
    dones = 0;
    repeat (20) begin
      if (done4 === 1'b1 || done1 === 1'b1) dones++;
      tick();
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL rst_no_done got=%0d expected 0", dones); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_fast_path();
    test_flush();
    test_ignored_start();
    test_bpc4();
    test_rst_mid_calc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_muldiv_unit.md
Name: rv_muldiv_unit

Overview:
- Parametrised iterative multiply/divide execute unit implementing the RV32M/RV64M operation set.
- Successor to the single-cycle combinational ALU op set; handles the operations that are too costly to do in one cycle.
- Sits beside the ALU in the execute stage: the pipeline issues one op, stalls on `busy`, and takes the result on a one-cycle `done` pulse.
- Supports abort through `flush`.

Parameters:
- WIDTH, 32, operand/result width in bits; legal values 32 or 64.
- BITS_PER_CYCLE, 1, quotient/multiplier bits processed per CALC cycle; legal values 1, 2, 4; WIDTH % BITS_PER_CYCLE == 0.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  synchronous reset, active-high.
- start  in  1  issue request; accepted only when `ready`=1.
- op  in  3  operation, RISC-V funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1  in  WIDTH  operand A: multiplicand or dividend.
- rs2  in  WIDTH  operand B: multiplier or divisor.
- flush  in  1  abort any in-flight op.
- ready  out  1  unit can accept `start` this cycle.
- busy  out  1  op in progress, result not yet available.
- done  out  1  one-cycle pulse; `result` is valid this cycle.
- result  out  WIDTH  registered result; holds its value until the next `done`.

Behaviour:
- Clocking and reset: one clock, CLK. Reset is synchronous and active-high on RST. Reset forces state=IDLE, busy=0, done=0, result=0, internal counter=0. RST asserted mid-op drops the op with no `done`.
- Let N = WIDTH/BITS_PER_CYCLE.
- States:
  - IDLE: ready=1, busy=0.
  - CALC: ready=0, busy=1.
  - FIN: ready=1, busy=0, done=1.
- Transitions:
  - IDLE/FIN, start=1, normal op -> CALC. Latch op; latch absolute values of operands according to signedness; latch result-sign flags; counter=N-1.
  - IDLE/FIN, start=1, fast-path op -> FIN directly.
  - CALC, counter>0 -> CALC, counter--.
  - CALC, counter==0 -> FIN.
  - FIN, start=0 -> IDLE.
- Latency: `start` sampled at edge k gives normal ops `done` in cycle k+N+1 (N CALC cycles) and fast-path ops `done` in cycle k+1.
- Back-to-back: `start` during the FIN cycle is accepted. The next op's CALC begins at the following edge with no IDLE bubble.
- Ignored start: `start` while in CALC is ignored, with no queuing.
- Multiply:
  - Unsigned shift-add over |A| and |B|, producing a 2*WIDTH product. BITS_PER_CYCLE multiplier bits consumed per cycle.
  - Signedness: MUL and MULH treat both operands as signed; MULHSU treats A as signed and B as unsigned; MULHU treats both as unsigned.
  - Final product is negated when the operand signs differ (signed operands only).
  - MUL returns product[WIDTH-1:0]. MULH, MULHSU and MULHU return product[2W-1:W].
- Divide:
  - Restoring division on |A| / |B|, BITS_PER_CYCLE quotient bits per cycle. DIVU and REMU are unsigned; DIV and REM are signed.
  - Quotient is negated if the operand signs differ; it truncates toward zero.
  - Remainder takes the sign of the dividend.
  - DIV and DIVU return the quotient; REM and REMU return the remainder.
- Fast paths, all with 1-cycle latency:
  - Divisor == 0: DIV/DIVU result = all ones; REM/REMU result = rs1.
  - Signed overflow (rs1 = most-negative, rs2 = -1): DIV result = rs1; REM result = 0.
  - Multiply has no fast path.
- Result update: the sign correction and result selection are computed in the CALC->FIN transition. `result` register is written at entry to FIN.
- Flush:
  - flush=1 in any state -> IDLE at the next edge; done=0; `result` is unchanged.
  - flush and start in the same cycle: flush wins and start is dropped.
  - flush in the FIN cycle does not retract that cycle's `done`.
- All arithmetic is modulo 2^WIDTH (or 2^(2*WIDTH) for the product). No X propagation from unused operand bits.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3), WIDTH=32, BPC=1, start at edge k -> busy cycles k+1..k+32; done in cycle k+33 only; result=0xFFFFFFEB.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Fast paths, each done at k+1 and busy never high:
  - DIVU x/0 -> 0xFFFFFFFF.
  - REM 0x1234/0 -> 0x1234.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM with the same operands -> 0.
- Flush at CALC cycle 10 -> no done pulse, IDLE next edge, previous result held. A start asserted with flush is dropped. A subsequent start completes normally.
- BPC=4, DIVU 0xFFFFFFFF/3 -> done at k+9, result=0x55555555. A new start in the FIN cycle -> next done at k+18. RST mid-CALC -> all outputs 0 at the next edge.
